// File: rtl/dec_out_fifo_if.sv
// Sample stream between fir_decimator, the output FIFO and its downstream consumer.
// slave is the FIFO side; master is the producer/consumer environment side.
interface dec_out_fifo_if #(
    parameter int SAMPLE_SIZE = 16,
    parameter int TAG_W       = 8
);
    logic [SAMPLE_SIZE-1:0] din;
    logic                   din_stb;
    logic [SAMPLE_SIZE-1:0] m_data;
    logic [TAG_W-1:0]       m_tag;
    logic                   m_valid;
    logic                   m_ready;

    modport slave (
        input  din, din_stb, m_ready,
        output m_data, m_tag, m_valid
    );

    modport master (
        output din, din_stb, m_ready,
        input  m_data, m_tag, m_valid
    );
endinterface

// File: rtl/dec_out_fifo.sv
// Output buffer for fir_decimator: tags strobed samples with a sequence number,
// stores them in a circular RAM behind a registered output stage, counts drops.
module dec_out_fifo #(
    parameter int SAMPLE_SIZE = 16,
    parameter int DEPTH       = 8,
    parameter int TAG_W       = 8,
    parameter int OVF_W       = 8
) (
    input  logic                        clk,
    input  logic                        nrst,
    dec_out_fifo_if.slave               bus,
    input  logic                        clr,
    output logic [$clog2(DEPTH+2)-1:0]  level,
    output logic                        ovf,
    output logic [OVF_W-1:0]            ovf_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LVL_W = $clog2(DEPTH + 2);
    localparam int ENT_W = TAG_W + SAMPLE_SIZE;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ENT_W-1:0]       mem_q [DEPTH];

    logic [SAMPLE_SIZE-1:0] m_data_q,  m_data_d;
    logic [TAG_W-1:0]       m_tag_q,   m_tag_d;
    logic                   m_valid_q, m_valid_d;
    logic [PTR_W-1:0]       wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]       count_q,   count_d;
    logic [TAG_W-1:0]       seq_q,     seq_d;
    logic [LVL_W-1:0]       level_q,   level_d;
    logic                   ovf_q,     ovf_d;
    logic [OVF_W-1:0]       ovf_cnt_q, ovf_cnt_d;

    logic                   pop, loadable, head_load, bypass, room, wr_en, drop;
    logic [ENT_W-1:0]       head;

    always_comb begin
        pop       = m_valid_q & bus.m_ready;
        loadable  = ~m_valid_q | pop;
        head_load = loadable && (count_q != '0);
        bypass    = loadable && (count_q == '0) && bus.din_stb;
        // A full RAM still accepts a write when its head moves out this cycle.
        room      = (count_q < DEPTH_C) || head_load;
        wr_en     = bus.din_stb && !bypass && room;
        drop      = bus.din_stb && !bypass && !room;
        head      = mem_q[rd_ptr_q];

        m_data_d  = m_data_q;
        m_tag_d   = m_tag_q;
        m_valid_d = m_valid_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        seq_d     = seq_q;
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;

        if (head_load) begin
            m_valid_d = 1'b1;
            m_tag_d   = head[ENT_W-1 -: TAG_W];
            m_data_d  = head[SAMPLE_SIZE-1:0];
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        end else if (bypass) begin
            m_valid_d = 1'b1;
            m_tag_d   = seq_q;
            m_data_d  = bus.din;
        end else begin
            m_valid_d = m_valid_q & ~pop;
        end

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(wr_en) - CNT_W'(head_load);

        if (bus.din_stb) begin
            seq_d = seq_q + TAG_W'(1);
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (ovf_cnt_q != '1) begin
                ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
            end
        end

        if (clr) begin
            m_valid_d = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            seq_d     = '0;
            ovf_d     = 1'b0;
            ovf_cnt_d = '0;
            wr_en     = 1'b0;
        end

        level_d = LVL_W'(count_d) + LVL_W'(m_valid_d);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_data_q  <= '0;
            m_tag_q   <= '0;
            m_valid_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            seq_q     <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            m_data_q  <= m_data_d;
            m_tag_q   <= m_tag_d;
            m_valid_q <= m_valid_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            seq_q     <= seq_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    // Storage carries no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {seq_q, bus.din};
        end
    end

    assign bus.m_data  = m_data_q;
    assign bus.m_tag   = m_tag_q;
    assign bus.m_valid = m_valid_q;
    assign level       = level_q;
    assign ovf         = ovf_q;
    assign ovf_cnt     = ovf_cnt_q;
endmodule
